// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, state encoding and direction constants for the ALU step stage
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic DIR_DEC = 1'b0;
    localparam logic DIR_INC = 1'b1;

endpackage

// File: rtl/incdec_step.sv
// rtl/incdec_step.sv - combinational +/-1 step unit with wrap detection
module incdec_step
    import alu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] operand,
    input  logic         dir,
    output logic [W-1:0] result,
    output logic         wrap_out
);

    // Modulo step; wrap flags the all-ones increment or the zero decrement.
    always_comb begin
        if (dir == DIR_INC) begin
            result   = operand + W'(1);
            wrap_out = &operand;
        end else begin
            result   = operand - W'(1);
            wrap_out = ~|operand;
        end
    end

endmodule

// File: rtl/incdec_seq.sv
// rtl/incdec_seq.sv - multi-step count-up/count-down sequencer around incdec_step
module incdec_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CNT_W = alu_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               wrap_q, wrap_d;

    logic [WIDTH-1:0]   step_result;
    logic               step_wrap;

    // The step unit always sees the live accumulator and the direction latched at start.
    incdec_step #(
        .W (WIDTH)
    ) u_step (
        .operand  (acc_q),
        .dir      (dir_q),
        .result   (step_result),
        .wrap_out (step_wrap)
    );

    // State register; reset abandons any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load wins over start and start is dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!load && start) begin
                    state_d = (steps != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from state so busy and done can never overlap.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        acc  = acc_q;
        wrap = wrap_q;
    end

    // Datapath next values: load/start only act in IDLE, stepping only in RUN.
    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        dir_d  = dir_q;
        wrap_d = wrap_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    acc_d  = load_val;
                    wrap_d = 1'b0;
                end else if (start) begin
                    dir_d  = dir;
                    rem_d  = steps;
                    wrap_d = 1'b0;
                end
            end
            S_RUN: begin
                acc_d  = step_result;
                wrap_d = wrap_q | step_wrap;
                rem_d  = rem_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            rem_q  <= '0;
            dir_q  <= DIR_DEC;
            wrap_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: tb/tb_incdec_seq.sv
// tb/tb_incdec_seq.sv - directed self-checking bench for incdec_seq
module tb_incdec_seq;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       dir;
    logic [3:0] steps;
    logic [7:0] acc;
    logic       busy;
    logic       done;
    logic       wrap;

    int vec_cnt;
    int miss_cnt;

    incdec_seq dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .dir      (dir),
        .steps    (steps),
        .acc      (acc),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    // Issue start at E0, then step until done; returns number of busy cycles seen.
    task automatic run(input logic d, input logic [3:0] n, output int busy_cycles, output bit timed_out);
        start = 1'b1;
        dir = d;
        steps = n;
        step();
        start = 1'b0;
        dir = ~d;
        steps = 4'hF;
        busy_cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            step();
        end
    endtask

    int bc;
    bit to;

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        rst = 1'b1;
        load = 1'b0;
        load_val = 8'h00;
        start = 1'b0;
        dir = 1'b0;
        steps = 4'h0;
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("rst_acc", acc, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);

        // Reset mid-run: 5 -> 6 -> 7, then reset.
        do_load(8'h05);
        start = 1'b1; dir = 1'b1; steps = 4'd4;
        step();
        start = 1'b0;
        chk("mid_busy_e0", busy, 1);
        step();
        step();
        chk("mid_acc_e2", acc, 8'h07);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_acc", acc, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_wrap", wrap, 0);
        step();
        chk("mid_no_done", done, 0);
        step();
        chk("mid_no_done2", done, 0);

        // Increment run 5 + 3 = 8.
        do_load(8'h05);
        run(1'b1, 4'd3, bc, to);
        chk("inc_timeout", to, 0);
        chk("inc_busy_cycles", bc, 3);
        chk("inc_acc", acc, 8'h08);
        chk("inc_wrap", wrap, 0);
        step();
        chk("inc_done_drop", done, 0);
        chk("inc_acc_hold", acc, 8'h08);

        // Decrement through zero: 1 -> 0 -> FF -> FE.
        do_load(8'h01);
        run(1'b0, 4'd3, bc, to);
        chk("dec_timeout", to, 0);
        chk("dec_busy_cycles", bc, 3);
        chk("dec_acc", acc, 8'hFE);
        chk("dec_wrap", wrap, 1);
        step();
        step();
        chk("dec_wrap_sticky_idle", wrap, 1);

        // Increment from all-ones, then a zero-step run.
        do_load(8'hFF);
        chk("load_clears_wrap", wrap, 0);
        run(1'b1, 4'd1, bc, to);
        chk("incw_timeout", to, 0);
        chk("incw_acc", acc, 8'h00);
        chk("incw_wrap", wrap, 1);
        step();
        run(1'b1, 4'd0, bc, to);
        chk("zero_timeout", to, 0);
        chk("zero_busy_cycles", bc, 0);
        chk("zero_acc", acc, 8'h00);
        chk("zero_wrap_cleared", wrap, 0);
        step();
        chk("zero_done_drop", done, 0);

        // Load beats start.
        load = 1'b1; start = 1'b1; load_val = 8'h94; dir = 1'b1; steps = 4'd2;
        step();
        load = 1'b0; start = 1'b0;
        chk("prio_acc", acc, 8'h94);
        chk("prio_busy", busy, 0);
        chk("prio_done", done, 0);
        step();
        chk("prio_no_run", busy, 0);
        chk("prio_acc_hold", acc, 8'h94);

        // load/start during RUN are ignored: 94 + 4 = 98.
        start = 1'b1; dir = 1'b1; steps = 4'd4;
        step();
        load = 1'b1; load_val = 8'h10; dir = 1'b0; steps = 4'd1;
        step();
        chk("ign_acc_e1", acc, 8'h95);
        chk("ign_busy_e1", busy, 1);
        step();
        load = 1'b0; start = 1'b0;
        bc = 0;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            step();
        end
        chk("ign_timeout", to, 0);
        chk("ign_acc", acc, 8'h98);
        chk("ign_wrap", wrap, 0);
        step();
        chk("ign_idle", busy, 0);
        chk("ign_acc_hold", acc, 8'h98);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
